// File: rtl/mul_div_e.sv
// Iterative multiply/divide unit for the Execute stage.
// Holds the architectural HI/LO pair and takes 33 cycles per MULT/MULTU/DIV/DIVU.
module mul_div_e #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StartE,
    input  logic [1:0]       MdOpE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    input  logic             HiWriteE,
    input  logic             LoWriteE,
    input  logic             AbortE,
    output logic [WIDTH-1:0] HiE,
    output logic [WIDTH-1:0] LoE,
    output logic             BusyE,
    output logic             DoneE
);

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    state_e             state;
    logic [CNT_W-1:0]   cnt;
    logic               op_div;
    logic               sign_q;
    logic               sign_r;
    logic               b_zero;
    logic [WIDTH-1:0]   raw_a;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    logic               done;

    logic               neg_a;
    logic               neg_b;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;
    logic               last_iter;

    // MdOpE[0] clear means signed; magnitudes feed the unsigned datapath.
    always_comb begin
        neg_a     = !MdOpE[0] && SrcAE[WIDTH-1];
        neg_b     = !MdOpE[0] && SrcBE[WIDTH-1];
        abs_a     = neg_a ? -SrcAE : SrcAE;
        abs_b     = neg_b ? -SrcBE : SrcBE;
        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd};
        prod      = {acc_hi, acc_lo};
        prod_fix  = sign_q ? -prod : prod;
        q_fix     = sign_q ? -acc_lo : acc_lo;
        r_fix     = sign_r ? -acc_hi : acc_hi;
        last_iter = (cnt == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= StIdle;
            cnt    <= '0;
            op_div <= 1'b0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            b_zero <= 1'b0;
            raw_a  <= '0;
            opnd   <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (HiWriteE) hi <= SrcAE;
                    if (LoWriteE) lo <= SrcAE;
                    if (StartE && !AbortE) begin
                        state  <= StRun;
                        cnt    <= '0;
                        op_div <= MdOpE[1];
                        raw_a  <= SrcAE;
                        b_zero <= (SrcBE == '0);
                        sign_q <= neg_a ^ neg_b;
                        sign_r <= neg_a;
                        acc_hi <= '0;
                        // Divide shifts the dividend out of acc_lo; multiply shifts the multiplier.
                        if (MdOpE[1]) begin
                            acc_lo <= abs_a;
                            opnd   <= abs_b;
                        end else begin
                            acc_lo <= abs_b;
                            opnd   <= abs_a;
                        end
                    end
                end
                StRun: begin
                    if (AbortE) begin
                        state <= StIdle;
                    end else begin
                        if (op_div) begin
                            acc_hi <= div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], ~div_diff[WIDTH]};
                        end else begin
                            acc_hi <= mul_sum[WIDTH:1];
                            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                        end
                        cnt <= cnt + 1'b1;
                        if (last_iter) state <= StFix;
                    end
                end
                StFix: begin
                    state <= StIdle;
                    if (!AbortE) begin
                        done <= 1'b1;
                        if (!op_div) begin
                            {hi, lo} <= prod_fix;
                        end else if (b_zero) begin
                            hi <= raw_a;
                            lo <= '1;
                        end else begin
                            hi <= r_fix;
                            lo <= q_fix;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign HiE   = hi;
    assign LoE   = lo;
    assign BusyE = (state != StIdle);
    assign DoneE = done;

endmodule

// File: tb/tb_mul_div_e.sv
// Directed self-checking bench for mul_div_e: results, timing, corners, interference.
module tb_mul_div_e;

    logic        clk = 1'b0;
    logic        reset;
    logic        StartE;
    logic [1:0]  MdOpE;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic        HiWriteE;
    logic        LoWriteE;
    logic        AbortE;
    logic [31:0] HiE;
    logic [31:0] LoE;
    logic        BusyE;
    logic        DoneE;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [1:0] OpMult = 2'b00, OpMultu = 2'b01, OpDiv = 2'b10, OpDivu = 2'b11;

    mul_div_e #(.WIDTH(32), .CNT_W(6)) dut (
        .clk      (clk),
        .reset    (reset),
        .StartE   (StartE),
        .MdOpE    (MdOpE),
        .SrcAE    (SrcAE),
        .SrcBE    (SrcBE),
        .HiWriteE (HiWriteE),
        .LoWriteE (LoWriteE),
        .AbortE   (AbortE),
        .HiE      (HiE),
        .LoE      (LoE),
        .BusyE    (BusyE),
        .DoneE    (DoneE)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        StartE   = 1'b0;
        HiWriteE = 1'b0;
        LoWriteE = 1'b0;
        AbortE   = 1'b0;
    endtask

    // Launch one op; optionally pulse StartE/moves at cycle `inject` and move-with-start.
    task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo, input int inject, input bit mt_start);
        int busy_n;
        int done_n;
        int done_at;
        busy_n  = 0;
        done_n  = 0;
        done_at = -1;
        @(negedge clk);
        StartE   = 1'b1;
        MdOpE    = op;
        SrcAE    = a;
        SrcBE    = b;
        HiWriteE = mt_start;
        LoWriteE = mt_start;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            idle_inputs();
            if (i == 1) begin
                SrcAE = 32'hA5A5_A5A5;
                SrcBE = 32'h0000_0003;
                MdOpE = ~op;
                if (mt_start) begin
                    check({tag, "_mthi_start"}, {32'h0, HiE}, {32'h0, a});
                    check({tag, "_mtlo_start"}, {32'h0, LoE}, {32'h0, a});
                end
            end
            if (BusyE) busy_n++;
            if (DoneE) begin
                done_n++;
                done_at = i;
            end
            if (i == inject) begin
                StartE   = 1'b1;
                HiWriteE = 1'b1;
                LoWriteE = 1'b1;
                SrcAE    = 32'h1111_1111;
                MdOpE    = OpDivu;
            end
        end
        check({tag, "_busy_cycles"}, 64'(busy_n), 64'd33);
        check({tag, "_done_count"}, 64'(done_n), 64'd1);
        check({tag, "_done_at"}, 64'(done_at), 64'd34);
        check({tag, "_hi"}, {32'h0, HiE}, {32'h0, exp_hi});
        check({tag, "_lo"}, {32'h0, LoE}, {32'h0, exp_lo});
    endtask

    task automatic move_hilo(input logic [31:0] hv, input logic [31:0] lv);
        @(negedge clk);
        HiWriteE = 1'b1;
        SrcAE    = hv;
        @(negedge clk);
        HiWriteE = 1'b0;
        LoWriteE = 1'b1;
        SrcAE    = lv;
        @(negedge clk);
        LoWriteE = 1'b0;
    endtask

    initial begin
        int done_n;
        idle_inputs();
        MdOpE = 2'b00;
        SrcAE = '0;
        SrcBE = '0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_hi", {32'h0, HiE}, 64'h0);
        check("rst_lo", {32'h0, LoE}, 64'h0);
        check("rst_busy", {63'h0, BusyE}, 64'h0);
        check("rst_done", {63'h0, DoneE}, 64'h0);
        reset = 1'b1;

        do_op("multu_max", OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, -1, 1'b0);
        do_op("mult_neg", OpMult, 32'hFFFF_FFF9, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFEB, -1, 1'b0);
        do_op("mult_minmin", OpMult, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0, -1, 1'b0);
        do_op("div_neg", OpDiv, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, -1, 1'b0);
        do_op("div_negb", OpDiv, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, -1, 1'b0);
        do_op("divu", OpDivu, 32'd100, 32'd7, 32'd2, 32'd14, -1, 1'b0);
        do_op("divu_zero", OpDivu, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, -1, 1'b0);
        do_op("div_zero", OpDiv, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, -1, 1'b0);
        do_op("div_ovf", OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, -1, 1'b0);
        do_op("mult_interf", OpMult, 32'd6, 32'd7, 32'h0, 32'd42, 5, 1'b0);
        do_op("multu_mt", OpMultu, 32'd2, 32'd3, 32'h0, 32'd6, -1, 1'b1);

        move_hilo(32'h1234, 32'h5678);
        check("mt_hi", {32'h0, HiE}, 64'h1234);
        check("mt_lo", {32'h0, LoE}, 64'h5678);
        check("mt_busy", {63'h0, BusyE}, 64'h0);

        // Abort in IDLE suppresses a same-cycle start.
        @(negedge clk);
        StartE = 1'b1;
        AbortE = 1'b1;
        MdOpE  = OpDivu;
        SrcAE  = 32'd9;
        SrcBE  = 32'd2;
        @(negedge clk);
        idle_inputs();
        check("idle_abort_busy", {63'h0, BusyE}, 64'h0);

        // Abort at cycle 20 of a DIV.
        @(negedge clk);
        StartE = 1'b1;
        MdOpE  = OpDiv;
        SrcAE  = 32'd100;
        SrcBE  = 32'd7;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            idle_inputs();
        end
        AbortE = 1'b1;
        @(negedge clk);
        AbortE = 1'b0;
        check("abort_busy", {63'h0, BusyE}, 64'h0);
        check("abort_done", {63'h0, DoneE}, 64'h0);
        check("abort_hi", {32'h0, HiE}, 64'h1234);
        check("abort_lo", {32'h0, LoE}, 64'h5678);
        do_op("after_abort", OpDivu, 32'd100, 32'd7, 32'd2, 32'd14, -1, 1'b0);

        // Reset mid-DIV at cycle 10 discards the op.
        @(negedge clk);
        StartE = 1'b1;
        MdOpE  = OpDiv;
        SrcAE  = 32'd50;
        SrcBE  = 32'd3;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            idle_inputs();
        end
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("midrst_hi", {32'h0, HiE}, 64'h0);
        check("midrst_lo", {32'h0, LoE}, 64'h0);
        check("midrst_busy", {63'h0, BusyE}, 64'h0);
        done_n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (DoneE) done_n++;
        end
        check("midrst_no_done", 64'(done_n), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mul_div_e.md
Name: mul_div_e

Overview:
- Iterative multiply/divide unit in the Execute stage.
- Consumes register operands launched by the decode-to-execute pipeline register and maintains the architectural HI/LO pair for MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Runs multi-cycle and raises BusyE to the hazard unit, which stalls Fetch/Decode and blocks MFHI/MFLO until DoneE.

Parameters:
- WIDTH, 32, operand width and HI/LO width.
- CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge)
- StartE  input  1  begin operation in MdOpE (honoured only in IDLE)
- MdOpE  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- SrcAE  input  WIDTH  rs operand: multiplicand / dividend; also MTHI/MTLO data
- SrcBE  input  WIDTH  rt operand: multiplier / divisor
- HiWriteE  input  1  MTHI: HI <= SrcAE
- LoWriteE  input  1  MTLO: LO <= SrcAE
- AbortE  input  1  cancel in-flight operation (branch/exception flush)
- HiE  output  WIDTH  architectural HI
- LoE  output  WIDTH  architectural LO
- BusyE  output  1  operation in flight, stall request
- DoneE  output  1  one-cycle pulse, HI/LO just updated by an operation

Behaviour:
- Reset (reset=0 at edge):
  - State = IDLE.
  - HiE = LoE = 0; BusyE = 0; DoneE = 0.
  - Counter and working registers cleared.
  - Applies mid-operation too: any in-flight result is discarded.
- States:
  - IDLE -> RUN on StartE.
  - RUN holds 32 cycles, counter 0..31, then -> FIX.
  - FIX -> IDLE.
- StartE in IDLE, edge E0:
  - Latch operands and op.
  - Signed ops (MULT, DIV) latch |SrcAE| and |SrcBE| and record result signs.
  - Counter = 0; enter RUN.
- RUN: one iteration per cycle.
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring, one quotient bit per cycle on a (WIDTH+1)-bit partial remainder.
- FIX, at edge E0+33:
  - Apply sign correction.
  - Write HI/LO, go to IDLE.
  - DoneE = 1 for the cycle following E0+33 only.
- Timing:
  - BusyE = 1 in the 33 cycles after E0 (RUN and FIX); 0 in IDLE.
  - Results visible on HiE/LoE from the cycle after E0+33.
- Results:
  - MULT/MULTU: {HI,LO} = full 64-bit product, two's complement for MULT.
  - DIV/DIVU: LO = quotient, HI = remainder.
  - Signed quotient truncates toward zero; remainder takes the sign of the dividend.
- Divide by zero (SrcBE = 0), signed or unsigned:
  - No trap, no sign fix.
  - LO = all ones; HI = SrcAE as latched, raw.
- Signed overflow (DIV, -2^31 / -1): LO = 0x80000000, HI = 0.
- StartE while BusyE = 1: ignored; no restart, no queueing.
- HiWriteE/LoWriteE:
  - In IDLE: HI/LO written at the edge, no busy, no DoneE.
  - While BusyE = 1: ignored.
  - Same cycle as StartE in IDLE: the move is applied at that edge; the operation result overwrites HI/LO at completion.
- AbortE:
  - While busy: return to IDLE at that edge; HI/LO unchanged; no DoneE; BusyE low next cycle.
  - In IDLE: ignored, and StartE in the same cycle is suppressed.
  - Abort during FIX cycle: abort wins, no write.
- Operand changes on SrcAE/SrcBE after E0 have no effect.

Test Plan:
- Reset: reset=0 mid-DIV at cycle 10 -> next cycle HiE = LoE = 0, BusyE = 0; no DoneE ever fires for that op.
- MULTU 0xFFFFFFFF * 0xFFFFFFFF -> BusyE high 33 cycles; HiE = 0xFFFFFFFE, LoE = 0x00000001; DoneE single pulse.
- MULT -7 * 3 -> HiE = 0xFFFFFFFF, LoE = 0xFFFFFFEB.
- DIV:
  - -7 / 2 -> LoE = 0xFFFFFFFD, HiE = 0xFFFFFFFF.
  - DIVU 100 / 7 -> LoE = 14, HiE = 2.
- Corners:
  - DIVU 5 / 0 -> LoE = 0xFFFFFFFF, HiE = 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> LoE = 0x80000000, HiE = 0.
- Interference: during MULT, pulse StartE, HiWriteE and LoWriteE -> all ignored, result unchanged. AbortE at cycle 20 of a DIV -> HI/LO keep prior MTHI/MTLO values (0x1234/0x5678), no DoneE; a new StartE accepted the next cycle.
